clock_gen: RTL and testbench
============================

# clock_gen

Parametrised, synthesizable clock/enable generator that replaces the free-running simulation clock in the processor project. It derives `N_CH` independent divided outputs from the single system clock. Each channel runs in toggle mode (50 % duty square wave, period 2·D cycles) or pulse mode (one-cycle tick every D cycles). Divisor and mode are reprogrammed at run time through a valid/ready port, with glitch-free application and glitch-free stop.

## Interface
- `N_CH`, 2: number of output channels (1..16).
- `DIV_W`, 16: divisor width in bits.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset (1..2^DIV_W-1).
- `CH_W`, `$clog2(N_CH)` (min 1): channel-select width; derived, not overridden.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration slot free.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_div`  in  DIV_W  new divisor D.
- `cfg_mode`  in  1  0 = toggle, 1 = pulse.
- `run_en`  in  N_CH  per-channel run request.
- `out_clk`  out  N_CH  divided outputs, registered.
- `tick`  out  N_CH  one-cycle pulse at each terminal count, registered.

## Operation
- **Per-channel state:** `cnt[DIV_W]`, `div`, `mode`, `running`, `out_clk`, `tick`.
- **Counting:**
  - While `running`, on each edge: if `cnt == div-1` then `cnt<=0`, `tick<=1`, else `cnt<=cnt+1`, `tick<=0`.
  - At terminal count, toggle mode flips `out_clk`. In pulse mode `out_clk` equals `tick`.
- **Divisor 1:** `div == 1` gives `tick` every cycle; toggle output is clk/2.
- **Start:** `run_en[i]` 0→1 while stopped sets `running`. `cnt` starts from 0.
- **Stop:** `run_en[i]` 0 with `out_clk[i]` low (or pulse mode) stops at that edge: `cnt<=0`, `tick<=0`.
  - In toggle mode with `out_clk` high, the channel keeps counting to its next terminal count, drives `out_clk` low, then stops. There are no runt pulses.
  - If `run_en` reasserts during this drain, the stop is cancelled and counting continues uninterrupted.
- **Configuration:** single shared pending slot; `cfg_ready = !pending`.
  - Handshake completes when `cfg_valid && cfg_ready` at an edge. The request is captured and `pending` is set.
  - `cfg_div == 0` is clamped to 1.
  - `cfg_ch >= N_CH` is accepted and discarded; `pending` stays 0.
- **Applying a pending request:**
  - Target channel stopped: applied at the next edge.
  - Target channel running: applied at its next terminal count edge; `cnt<=0` at that edge.
  - If the request is captured on the same edge as the target's terminal count, it waits for the following terminal count.
  - On a mode change, `out_clk` is forced to 0 at the apply edge. `tick` behaves normally for that edge.
  - `pending` clears on the apply edge, so `cfg_ready` is high in the next cycle.
- **Stop during pending:** if the target channel stops while a request is pending, the request applies on the edge after the stop.

## Timing
- **Reset (async, immediate):**
  - `out_clk = 0`, `tick = 0`, `cfg_ready = 1`.
  - All `cnt = 0`, `div = DEFAULT_DIV`, `mode = toggle`, `running = 0`, `pending = 0`.
  - Reset mid-period discards all state, including a pending request.
  - After release, nothing runs until `run_en` is sampled high.
- **Latency from start:** with `run_en` first sampled high at edge E0, the first `tick` is high in the cycle after edge E0+D-1. In toggle mode the first `out_clk` rise occurs at that same edge.
- **Steady state:** toggle period 2·D cycles, high for exactly D. Pulse period D cycles, high for 1.
- **Config throughput:** at most one request per apply. Worst case `cfg_ready` is low for D+1 cycles.
- **Channel independence:** channels do not interact except through the shared config slot.

## Test plan
- **Reset defaults:** reset, then `run_en = 2'b01`, defaults (D = 2) -> `out_clk[0]` period 4 cycles with 2 high, first rise 2 edges after `run_en` sampled. `out_clk[1]` and `tick[1]` stay 0.
- **Reconfigure while running:** channel 0 running at D = 2, write D = 5 toggle mid-period -> `cfg_ready` drops 1 cycle after handshake. The current half-period completes at the old length. Subsequent half-periods are exactly 5 cycles. `cfg_ready` returns high the cycle after apply.
- **Pulse mode and clamping:** program channel 1 to pulse mode with D = 3, then with D = 0 -> `tick[1]` = `out_clk[1]`, high 1 of every 3 cycles. After the second write (clamped to 1), high every cycle.
- **Glitch-free stop:** D = 4 toggle, deassert `run_en` 1 cycle after a rising `out_clk` -> output stays high 4 cycles total, falls, then holds 0 with `cnt = 0`. Reassert -> first rise 4 edges later.
- **Boundary cases:** handshake on the exact terminal-count edge -> applies one period later. `cfg_ch = N_CH` -> accepted, no channel changes, `cfg_ready` stays 1.
- **Reset mid-operation:** assert `rst_n` low mid-period with `pending = 1` -> all outputs 0 asynchronously (before next edge). After release, `div` has returned to `DEFAULT_DIV`.

Source files
------------

// File: rtl/clock_gen.sv
// clock_gen: N_CH independent divided-clock / tick outputs derived from one system clock,
// reprogrammed through a single shared valid/ready slot applied at each channel's terminal count.
module clock_gen #(
   parameter int  N_CH        = 2,
   parameter int  DIV_W       = 16,
   parameter int  DEFAULT_DIV = 2,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_mode,
   input  logic [N_CH-1:0]  run_en,
   output logic [N_CH-1:0]  out_clk,
   output logic [N_CH-1:0]  tick
);

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} ch_state_t;

   logic             pending;
   logic [CH_W-1:0]  pend_ch;
   logic [DIV_W-1:0] pend_div;
   logic             pend_mode;
   logic [N_CH-1:0]  apply;

   assign cfg_ready = !pending;

   // Out-of-range channel requests complete the handshake but are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         pend_ch   <= '0;
         pend_div  <= DIV_W'(1);
         pend_mode <= 1'b0;
      end else if (pending) begin
         if (|apply) pending <= 1'b0;
      end else if (cfg_valid && (int'(cfg_ch) < N_CH)) begin
         pending   <= 1'b1;
         pend_ch   <= cfg_ch;
         pend_div  <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
         pend_mode <= cfg_mode;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ch_state_t        state, state_nxt;
      logic [DIV_W-1:0] cnt, cnt_nxt, div, div_nxt, div_use;
      logic             mode, mode_nxt, mode_use;
      logic             oc, oc_nxt, tk, tk_nxt;
      logic             sel, counting, apply_ch;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= ST_STOP;
            cnt   <= '0;
            div   <= DIV_W'(DEFAULT_DIV);
            mode  <= 1'b0;
            oc    <= 1'b0;
            tk    <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            div   <= div_nxt;
            mode  <= mode_nxt;
            oc    <= oc_nxt;
            tk    <= tk_nxt;
         end
      end

      always_comb begin
         sel       = pending && (int'(pend_ch) == i);
         state_nxt = state;
         cnt_nxt   = cnt;
         div_nxt   = div;
         mode_nxt  = mode;
         oc_nxt    = oc;
         tk_nxt    = 1'b0;
         div_use   = div;
         mode_use  = mode;
         counting  = 1'b0;
         apply_ch  = 1'b0;

         case (state)
            ST_STOP: begin
               // A stopped channel takes the new setting immediately, even on its start edge.
               if (sel) begin
                  apply_ch = 1'b1;
                  div_use  = pend_div;
                  mode_use = pend_mode;
               end
               if (run_en[i]) begin
                  counting  = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (!run_en[i] && (mode || !oc)) begin
                  state_nxt = ST_STOP;
                  cnt_nxt   = '0;
                  oc_nxt    = 1'b0;
               end else begin
                  counting = 1'b1;
                  if (!run_en[i]) state_nxt = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               counting = 1'b1;
               if (run_en[i]) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_STOP;
         endcase

         if (counting) begin
            if (cnt == div_use - DIV_W'(1)) begin
               cnt_nxt = '0;
               tk_nxt  = 1'b1;
               oc_nxt  = mode_use | ~oc;
               // Terminal count without run_en ends a drain; the pending request waits an edge.
               if (!run_en[i]) state_nxt = ST_STOP;
               else if (sel && (state != ST_STOP)) apply_ch = 1'b1;
            end else begin
               cnt_nxt = cnt + DIV_W'(1);
               oc_nxt  = mode_use ? 1'b0 : oc;
            end
         end

         if (apply_ch) begin
            div_nxt  = pend_div;
            mode_nxt = pend_mode;
            if (pend_mode != mode) oc_nxt = 1'b0;
         end
      end

      assign apply[i]   = apply_ch;
      assign out_clk[i] = oc;
      assign tick[i]    = tk;
   end

endmodule

// File: tb/tb_clock_gen.sv
// Directed self-checking bench for clock_gen (3 channels so that an out-of-range cfg_ch is encodable).
module tb_clock_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_div;
   logic        cfg_mode;
   logic [2:0]  run_en;
   logic [2:0]  out_clk;
   logic [2:0]  tick;

   int n_assert = 0;
   int n_fail   = 0;

   clock_gen #(.N_CH(3), .DIV_W(16), .DEFAULT_DIV(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .run_en    (run_en),
      .out_clk   (out_clk),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Patterns are written first-cycle-first (MSB of the n-bit literal is the first edge).
   task automatic seq(input string tag, input int ch, input int n,
                      input logic [15:0] p_oc, input logic [15:0] p_tk, input logic [15:0] p_rd);
      for (int k = 0; k < n; k++) begin
         cyc();
         chk({tag, "_oc"},    16'(out_clk[ch]), 16'(p_oc[n-1-k]));
         chk({tag, "_tick"},  16'(tick[ch]),    16'(p_tk[n-1-k]));
         chk({tag, "_ready"}, 16'(cfg_ready),   16'(p_rd[n-1-k]));
      end
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [15:0] d, input logic m);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_div   = d;
      cfg_mode  = m;
   endtask

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0; run_en = '0;
      #2;
      chk("rst_out_clk", 16'(out_clk), 16'h0);
      chk("rst_tick",    16'(tick),    16'h0);
      chk("rst_ready",   16'(cfg_ready), 16'h1);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      chk("idle_out_clk", 16'(out_clk), 16'h0);

      // Defaults, D = 2 on channel 0
      run_en = 3'b001;
      seq("def", 0, 6, 16'b011001, 16'b010101, 16'b111111);
      chk("def_ch1", 16'({out_clk[1], tick[1]}), 16'h0);

      // Reconfigure channel 0 to D = 5 mid-period
      chk("reconf_ready_pre", 16'(cfg_ready), 16'h1);
      cfg(2'd0, 16'd5, 1'b0);
      cyc();
      cfg_valid = 1'b0;
      chk("reconf_ready_low", 16'(cfg_ready), 16'h0);
      chk("reconf_old_half",  16'(out_clk[0]), 16'h1);
      cyc();
      chk("reconf_apply_oc",   16'(out_clk[0]), 16'h0);
      chk("reconf_apply_tick", 16'(tick[0]),    16'h1);
      chk("reconf_ready_back", 16'(cfg_ready),  16'h1);
      seq("reconf", 0, 10, 16'b0000111110, 16'b0000100001, 16'b1111111111);

      // Handshake on the exact terminal-count edge applies one period later
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("tc_wait_oc", 16'(out_clk[0]), 16'h0);
      end
      cfg(2'd0, 16'd3, 1'b0);
      cyc();
      cfg_valid = 1'b0;
      chk("tc_edge_oc",    16'(out_clk[0]), 16'h1);
      chk("tc_edge_ready", 16'(cfg_ready),  16'h0);
      seq("tc", 0, 8, 16'b11110001, 16'b00001001, 16'b00001111);

      // Out-of-range channel is accepted and dropped
      cfg(2'd3, 16'd7, 1'b1);
      cyc();
      cfg_valid = 1'b0;
      chk("badch_ready0", 16'(cfg_ready),  16'h1);
      chk("badch_oc0",    16'(out_clk[0]), 16'h1);
      cyc();
      chk("badch_ready1", 16'(cfg_ready),  16'h1);
      chk("badch_oc1",    16'(out_clk[0]), 16'h1);
      cyc();
      chk("badch_oc2",    16'(out_clk[0]), 16'h0);
      chk("badch_tick2",  16'(tick[0]),    16'h1);
      chk("badch_ch2",    16'({out_clk[2], tick[2]}), 16'h0);

      // Channel 1 pulse mode D = 3, programmed while stopped
      cfg(2'd1, 16'd3, 1'b1);
      cyc();
      cfg_valid = 1'b0;
      chk("pulse_ready_low", 16'(cfg_ready), 16'h0);
      cyc();
      chk("pulse_ready_back", 16'(cfg_ready), 16'h1);
      chk("pulse_idle", 16'({out_clk[1], tick[1]}), 16'h0);
      run_en = 3'b011;
      seq("pulse", 1, 6, 16'b001001, 16'b001001, 16'b111111);

      // D = 0 clamps to 1: tick every cycle
      cfg(2'd1, 16'd0, 1'b1);
      cyc();
      cfg_valid = 1'b0;
      chk("clamp_tick0",  16'(tick[1]),   16'h0);
      chk("clamp_ready0", 16'(cfg_ready), 16'h0);
      seq("clamp", 1, 5, 16'b01111, 16'b01111, 16'b01111);

      // Pulse-mode stop is immediate
      run_en = 3'b001;
      cyc();
      chk("pstop_ch1", 16'({out_clk[1], tick[1]}), 16'h0);

      // Channel 0 to D = 4 toggle, then glitch-free stop
      cfg(2'd0, 16'd4, 1'b0);
      cyc();
      cfg_valid = 1'b0;
      chk("d4_ready_low", 16'(cfg_ready), 16'h0);
      chk("pstop_ch1b",   16'({out_clk[1], tick[1]}), 16'h0);
      cyc();
      chk("d4_oc_pre", 16'(out_clk[0]), 16'h1);
      cyc();
      chk("d4_apply_oc",    16'(out_clk[0]), 16'h0);
      chk("d4_apply_ready", 16'(cfg_ready),  16'h1);
      seq("d4", 0, 4, 16'b0001, 16'b0001, 16'b1111);
      cyc();
      chk("stop_oc_hi", 16'(out_clk[0]), 16'h1);
      run_en = 3'b000;
      seq("stop", 0, 5, 16'b11000, 16'b00100, 16'b11111);
      run_en = 3'b001;
      seq("restart", 0, 4, 16'b0001, 16'b0001, 16'b1111);

      // Asynchronous reset with a request pending
      cfg(2'd0, 16'd7, 1'b1);
      cyc();
      cfg_valid = 1'b0;
      chk("prerst_ready", 16'(cfg_ready),  16'h0);
      chk("prerst_oc",    16'(out_clk[0]), 16'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_clk", 16'(out_clk),   16'h0);
      chk("arst_tick",    16'(tick),      16'h0);
      chk("arst_ready",   16'(cfg_ready), 16'h1);
      cyc();
      rst_n = 1'b1;
      seq("postrst", 0, 4, 16'b0110, 16'b0101, 16'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
